// File: rtl/multi_phase_signal_ctrl_if.sv
// Signal-controller bus: vehicle demand in, lamps and status out.
// With EMERGENCY_PREEMPT_EN defined, the bus also carries preempt and preempt_ph.
interface multi_phase_signal_ctrl_if #(
    parameter int unsigned NUM_PHASES = 4
);
    localparam int unsigned PW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

    logic [NUM_PHASES-1:0] veh_req;
    logic [NUM_PHASES-1:0] red;
    logic [NUM_PHASES-1:0] yellow;
    logic [NUM_PHASES-1:0] green;
    logic [PW-1:0]         phase;
    logic [1:0]            ctrl_state;
`ifdef EMERGENCY_PREEMPT_EN
    logic                  preempt;
    logic [PW-1:0]         preempt_ph;

    modport master (
        input  veh_req, preempt, preempt_ph,
        output red, yellow, green, phase, ctrl_state
    );
    modport slave (
        output veh_req, preempt, preempt_ph,
        input  red, yellow, green, phase, ctrl_state
    );
`else
    modport master (
        input  veh_req,
        output red, yellow, green, phase, ctrl_state
    );
    modport slave (
        output veh_req,
        input  red, yellow, green, phase, ctrl_state
    );
`endif
endinterface

// File: rtl/multi_phase_signal_ctrl.sv
// N-phase round-robin traffic-signal controller with gap-out, max-out and all-red clearance.
// Optional emergency preemption is enabled by defining EMERGENCY_PREEMPT_EN.
module multi_phase_signal_ctrl #(
    parameter int unsigned NUM_PHASES = 4,
    parameter int unsigned TW         = 8,
    parameter int unsigned GREEN_T    = 25,
    parameter int unsigned MIN_GREEN  = 10,
    parameter int unsigned YELLOW_T   = 5,
    parameter int unsigned ALLRED_T   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    multi_phase_signal_ctrl_if.master bus
);
    localparam int unsigned PW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

    localparam logic [TW-1:0] GREEN_LAST  = TW'(GREEN_T - 1);
    localparam logic [TW-1:0] MIN_LAST    = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] YELLOW_LAST = TW'(YELLOW_T - 1);
    localparam logic [TW-1:0] ALLRED_LAST = TW'(ALLRED_T - 1);

    // Elaboration-time parameter range checks
    if (NUM_PHASES < 2 || NUM_PHASES > 8) begin : g_bad_num_phases
        $error("NUM_PHASES must be in 2..8");
    end
    if (GREEN_T < 1 || 64'(GREEN_T) > (64'd1 << TW)) begin : g_bad_green_t
        $error("GREEN_T must be in 1..2^TW");
    end
    if (MIN_GREEN < 1 || MIN_GREEN > GREEN_T) begin : g_bad_min_green
        $error("MIN_GREEN must be in 1..GREEN_T");
    end
    if (YELLOW_T < 1 || 64'(YELLOW_T) > (64'd1 << TW)) begin : g_bad_yellow_t
        $error("YELLOW_T must be in 1..2^TW");
    end
    if (ALLRED_T < 1 || 64'(ALLRED_T) > (64'd1 << TW)) begin : g_bad_allred_t
        $error("ALLRED_T must be in 1..2^TW");
    end

    typedef enum logic [1:0] {
        ST_GREEN   = 2'b00,
        ST_YELLOW  = 2'b01,
        ST_ALLRED  = 2'b10,
        ST_PREEMPT = 2'b11
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [PW-1:0]   target_q, target_d;
    logic [TW-1:0]   timer_q, timer_d;

    logic [PW-1:0]   nxt;
    logic [PW-1:0]   idx;
    logic            other_req;
    logic            gap_out;
    logic            max_out;
    logic [NUM_PHASES-1:0] lamp_g, lamp_y;

`ifdef EMERGENCY_PREEMPT_EN
    logic            preempt_hit;
    // Out-of-range preempt_ph requests are ignored so no lamp can go dark
    assign preempt_hit = bus.preempt && (32'(bus.preempt_ph) < NUM_PHASES);
`endif

    // Nearest demanding phase after the current one; the descending scan lets the closest win
    always_comb begin
        nxt       = phase_q;
        idx       = '0;
        other_req = 1'b0;
        for (int d = NUM_PHASES - 1; d >= 1; d--) begin
            idx = PW'((32'(phase_q) + 32'(d)) % 32'(NUM_PHASES));
            if (bus.veh_req[idx]) begin
                nxt       = idx;
                other_req = 1'b1;
            end
        end
    end

    assign gap_out = (timer_q >= MIN_LAST) && !bus.veh_req[phase_q];
    assign max_out = (timer_q == GREEN_LAST);

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        target_d = target_q;
        timer_d  = timer_q + TW'(1);
        case (state_q)
            ST_GREEN: begin
                timer_d = max_out ? timer_q : timer_q + TW'(1);
                if (other_req && (gap_out || max_out)) begin
                    state_d  = ST_YELLOW;
                    timer_d  = '0;
                    target_d = nxt;
                end
`ifdef EMERGENCY_PREEMPT_EN
                if (preempt_hit) begin
                    timer_d = '0;
                    if (bus.preempt_ph == phase_q) begin
                        state_d  = ST_PREEMPT;
                        target_d = target_q;
                    end else begin
                        state_d  = ST_YELLOW;
                        target_d = bus.preempt_ph;
                    end
                end
`endif
            end
            ST_YELLOW: begin
                if (timer_q == YELLOW_LAST) begin
                    state_d = ST_ALLRED;
                    timer_d = '0;
                end
`ifdef EMERGENCY_PREEMPT_EN
                if (preempt_hit) target_d = bus.preempt_ph;
`endif
            end
            ST_ALLRED: begin
`ifdef EMERGENCY_PREEMPT_EN
                if (preempt_hit) target_d = bus.preempt_ph;
`endif
                if (timer_q == ALLRED_LAST) begin
                    state_d = ST_GREEN;
                    timer_d = '0;
                    phase_d = target_d;
                end
            end
`ifdef EMERGENCY_PREEMPT_EN
            ST_PREEMPT: begin
                timer_d = '0;
                if (!bus.preempt) begin
                    state_d  = ST_YELLOW;
                    target_d = nxt;
                end
            end
`endif
            default: begin
                state_d  = ST_GREEN;
                phase_d  = '0;
                target_d = '0;
                timer_d  = '0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_GREEN;
            phase_q  <= '0;
            target_q <= '0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            target_q <= target_d;
            timer_q  <= timer_d;
        end
    end

    // Lamp decode: exactly one of red/yellow/green per phase
    always_comb begin
        lamp_g = '0;
        lamp_y = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (32'(phase_q) == 32'(i)) begin
`ifdef EMERGENCY_PREEMPT_EN
                lamp_g[i] = (state_q == ST_GREEN) || (state_q == ST_PREEMPT);
`else
                lamp_g[i] = (state_q == ST_GREEN);
`endif
                lamp_y[i] = (state_q == ST_YELLOW);
            end
        end
    end

    assign bus.green      = lamp_g;
    assign bus.yellow     = lamp_y;
    assign bus.red        = ~(lamp_g | lamp_y);
    assign bus.phase      = phase_q;
    assign bus.ctrl_state = 2'(state_q);

endmodule
